hand_position_tracker: RTL

HAND_POSITION_TRACKER -- requirements
Module: hand_position_tracker

---
 rtl/hand_tracker_pkg.sv | 17 +
 rtl/hand_pos_filter.sv | 26 ++
 rtl/hand_position_tracker.sv | 116 +++++++++++
 3 files changed

// File: rtl/hand_tracker_pkg.sv
// Shared types and constants for the hand position tracker: FSM state
// encoding, datapath widths and the default active-area geometry.
package hand_tracker_pkg;

  localparam int unsigned COORD_W      = 10;
  localparam int unsigned CNT_W        = 19;
  localparam int unsigned POS_W        = 32;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    ST_SCAN = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } track_state_t;

endpackage

// File: rtl/hand_pos_filter.sv
// Per-axis position update. HAND_POS_SMOOTH_EN selects a 3:1 exponential
// smoother (new = (3*old + raw) >> 2); otherwise the raw centre passes through.
module hand_pos_filter
  import hand_tracker_pkg::*;
(
  input  logic [COORD_W-1:0] old_pos,
  input  logic [COORD_W-1:0] raw_pos,
  output logic [COORD_W-1:0] new_pos
);

`ifdef HAND_POS_SMOOTH_EN
  // 12 bits hold 3*1023 + 1023 without overflow.
  logic [COORD_W+1:0] acc;

  always_comb begin
    acc     = ({2'b00, old_pos} << 1) + {2'b00, old_pos} + {2'b00, raw_pos};
    new_pos = acc[COORD_W+1:2];
  end
`else
  logic unused_old;

  assign unused_old = ^old_pos;
  assign new_pos    = raw_pos;
`endif

endmodule

// File: rtl/hand_position_tracker.sv
// Tracks the centre of the red-dominant bounding box in each camera frame.
// Optional smoothing of the published position is enabled by HAND_POS_SMOOTH_EN.
module hand_position_tracker
  import hand_tracker_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter logic [4:0]  R_MIN      = 5'd20,
  parameter logic [5:0]  G_MAX      = 6'd24,
  parameter int unsigned MIN_PIXELS = 64
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             frame_end,
  input  logic             pix_valid,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  input  logic [15:0]      pix_rgb,
  output logic [POS_W-1:0] x_position,
  output logic [POS_W-1:0] y_position,
  output logic             pos_found,
  output logic             pos_valid
);

  track_state_t state_q, state_d;
  logic scan_en, calc_en, out_en;

  logic [COORD_W-1:0] min_x, max_x, min_y, max_y;
  logic [CNT_W-1:0]   hit_cnt;
  logic               hit;

  logic [COORD_W:0]   sum_x, sum_y;
  logic [COORD_W-1:0] raw_x, raw_y, filt_x, filt_y;
  logic [COORD_W-1:0] x_pos_q, y_pos_q;
  logic               frame_ok;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= ST_SCAN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SCAN: if (frame_end) state_d = ST_CALC;
      ST_CALC: state_d = ST_OUT;
      ST_OUT:  state_d = ST_SCAN;
      default: state_d = ST_SCAN;
    endcase
  end

  always_comb begin
    scan_en = (state_q == ST_SCAN);
    calc_en = (state_q == ST_CALC);
    out_en  = (state_q == ST_OUT);
  end

  // Pixels arriving outside SCAN are dropped, including one coincident with frame_end in CALC/OUT.
  assign hit = scan_en && pix_valid
            && (32'(pix_x) < H_ACTIVE) && (32'(pix_y) < V_ACTIVE)
            && (pix_rgb[15:11] >= R_MIN) && (pix_rgb[10:5] <= G_MAX);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      min_x   <= '1;
      max_x   <= '0;
      min_y   <= '1;
      max_y   <= '0;
      hit_cnt <= '0;
    end else if (out_en) begin
      min_x   <= '1;
      max_x   <= '0;
      min_y   <= '1;
      max_y   <= '0;
      hit_cnt <= '0;
    end else if (hit) begin
      if (pix_x < min_x) min_x <= pix_x;
      if (pix_x > max_x) max_x <= pix_x;
      if (pix_y < min_y) min_y <= pix_y;
      if (pix_y > max_y) max_y <= pix_y;
      if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
    end
  end

  assign sum_x    = {1'b0, min_x} + {1'b0, max_x};
  assign sum_y    = {1'b0, min_y} + {1'b0, max_y};
  assign raw_x    = sum_x[COORD_W:1];
  assign raw_y    = sum_y[COORD_W:1];
  assign frame_ok = (32'(hit_cnt) >= MIN_PIXELS);

  hand_pos_filter u_filt_x (.old_pos(x_pos_q), .raw_pos(raw_x), .new_pos(filt_x));
  hand_pos_filter u_filt_y (.old_pos(y_pos_q), .raw_pos(raw_y), .new_pos(filt_y));

  // Results are registered on the CALC->OUT edge so they appear together with pos_valid.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      x_pos_q   <= COORD_W'(H_ACTIVE / 2);
      y_pos_q   <= COORD_W'(V_ACTIVE / 2);
      pos_found <= 1'b0;
      pos_valid <= 1'b0;
    end else begin
      pos_valid <= calc_en;
      if (calc_en) begin
        pos_found <= frame_ok;
        if (frame_ok) begin
          x_pos_q <= filt_x;
          y_pos_q <= filt_y;
        end
      end
    end
  end

  assign x_position = POS_W'(x_pos_q);
  assign y_position = POS_W'(y_pos_q);

endmodule
